// File: rtl/mandelbrot_pkg.sv
// Shared Mandelbrot definitions: FSM state type, escape bound and default Q-format
// constants used by both the iteration engine and the coordinate generator.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam int MANDEL_BOUND_INT = 4;

  localparam int DEF_WIDTH  = 46;
  localparam int DEF_FRAC   = 40;
  localparam int DEF_ITER_W = 16;

  // True for 1, 2, 4, 8, ... ; used to space out periodicity snapshots.
  function automatic logic is_pow2(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mandelbrot_iter_engine_if.sv
// Job/result handshake bundle for the Mandelbrot engine: one valid/ready channel
// carrying c and a tag in, one carrying the iteration result out.
interface mandelbrot_iter_engine_if #(
  parameter int WIDTH  = 46,
  parameter int ITER_W = 16,
  parameter int TAG_W  = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_c_real;
  logic signed [WIDTH-1:0] in_c_imag;
  logic [TAG_W-1:0]        in_tag;

  logic                    out_valid;
  logic                    out_ready;
  logic [ITER_W-1:0]       out_iter;
  logic                    out_escaped;
  logic                    out_periodic;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_c_real, in_c_imag, in_tag, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped, out_periodic, out_tag
  );

  modport slave (
    input  in_valid, in_c_real, in_c_imag, in_tag, out_ready,
    output in_ready, out_valid, out_iter, out_escaped, out_periodic, out_tag
  );

endinterface

// File: rtl/mandelbrot_step.sv
// Combinational single Mandelbrot step: from z and c produce z^2 + c (wrapping to
// WIDTH bits) and the strict |z|^2 > 4 escape flag for the current z.
module mandelbrot_step
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] next_zr,
  output logic signed [WIDTH-1:0] next_zi,
  output logic                    escaped
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = 2 * WIDTH - FRAC + 1;
  localparam logic signed [MW-1:0] BOUND = MW'(MANDEL_BOUND_INT) <<< FRAC;

  logic signed [PW-1:0] zr_x, zi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri;
  logic signed [MW-1:0] sq_r, sq_i, mag;

  assign zr_x = PW'(zr);
  assign zi_x = PW'(zi);

  assign p_rr = zr_x * zr_x;
  assign p_ii = zi_x * zi_x;
  assign p_ri = zr_x * zi_x;

  // One spare bit above the rescaled squares keeps the magnitude sum from wrapping.
  assign sq_r = MW'(p_rr >>> FRAC);
  assign sq_i = MW'(p_ii >>> FRAC);
  assign mag  = sq_r + sq_i;

  assign escaped = (mag > BOUND);

  assign next_zr = WIDTH'(p_rr >>> FRAC) - WIDTH'(p_ii >>> FRAC) + cr;
  assign next_zi = WIDTH'((p_ri >>> FRAC) <<< 1) + ci;

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Sequential Mandelbrot escape-time engine, one iteration per clock.
// Optional periodicity early-exit is enabled by defining MANDEL_PERIOD_CHECK_EN.
module mandelbrot_iter_engine
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int ITER_W   = DEF_ITER_W,
  parameter int MAX_ITER = 1000,
  parameter int TAG_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mandelbrot_iter_engine_if.slave  bus
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t                  state;
  logic signed [WIDTH-1:0] zr, zi, cr, ci;
  logic signed [WIDTH-1:0] next_zr, next_zi;
  logic                    escaped;
  logic [ITER_W-1:0]       iter;
  logic [TAG_W-1:0]        tag;

  mandelbrot_step #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_step (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr),
    .ci      (ci),
    .next_zr (next_zr),
    .next_zi (next_zi),
    .escaped (escaped)
  );

  assign bus.in_ready = (state == IDLE);

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [WIDTH-1:0] snap_r, snap_i;
  logic                    snap_vld;
  logic                    period_hit;

  assign period_hit = snap_vld && (zr == snap_r) && (zi == snap_i);
`else
  assign bus.out_periodic = 1'b0;
`endif

  // Escape beats the iteration limit, which beats a periodicity hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      zr              <= '0;
      zi              <= '0;
      cr              <= '0;
      ci              <= '0;
      iter            <= '0;
      tag             <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_iter    <= '0;
      bus.out_escaped <= 1'b0;
      bus.out_tag     <= '0;
`ifdef MANDEL_PERIOD_CHECK_EN
      bus.out_periodic <= 1'b0;
      snap_r           <= '0;
      snap_i           <= '0;
      snap_vld         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cr    <= bus.in_c_real;
            ci    <= bus.in_c_imag;
            tag   <= bus.in_tag;
            zr    <= '0;
            zi    <= '0;
            iter  <= '0;
            state <= ITER;
`ifdef MANDEL_PERIOD_CHECK_EN
            snap_vld <= 1'b0;
`endif
          end
        end
        ITER: begin
          if (escaped) begin
            bus.out_iter    <= iter;
            bus.out_escaped <= 1'b1;
            bus.out_tag     <= tag;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
`ifdef MANDEL_PERIOD_CHECK_EN
            bus.out_periodic <= 1'b0;
`endif
          end else if (iter == ITER_LIMIT) begin
            bus.out_iter    <= ITER_LIMIT;
            bus.out_escaped <= 1'b0;
            bus.out_tag     <= tag;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
`ifdef MANDEL_PERIOD_CHECK_EN
            bus.out_periodic <= 1'b0;
          end else if (period_hit) begin
            bus.out_iter     <= ITER_LIMIT;
            bus.out_escaped  <= 1'b0;
            bus.out_periodic <= 1'b1;
            bus.out_tag      <= tag;
            bus.out_valid    <= 1'b1;
            state            <= DONE;
`endif
          end else begin
            zr   <= next_zr;
            zi   <= next_zi;
            iter <= iter + 1'b1;
`ifdef MANDEL_PERIOD_CHECK_EN
            if (is_pow2(32'(iter))) begin
              snap_r   <= zr;
              snap_i   <= zi;
              snap_vld <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed testbench for mandelbrot_iter_engine with hand-computed escape counts,
// latencies, handshake stalls and mid-job reset; honours MANDEL_PERIOD_CHECK_EN.
module tb_mandelbrot_iter_engine;
  import mandelbrot_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int F     = DEF_FRAC;
  localparam int IW    = DEF_ITER_W;
  localparam int MAXI  = 1000;
  localparam int TW    = 16;
  localparam int LIMIT = 2000;
`ifdef MANDEL_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mandelbrot_iter_engine_if #(.WIDTH(W), .ITER_W(IW), .TAG_W(TW)) bus ();

  mandelbrot_iter_engine #(
    .WIDTH    (W),
    .FRAC     (F),
    .ITER_W   (IW),
    .MAX_ITER (MAXI),
    .TAG_W    (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] fx(input int v);
    logic signed [W-1:0] r;
    r = W'(v);
    return r <<< F;
  endfunction

  // Offer one job at a negedge and count edges from the accept edge to out_valid.
  task automatic applyStimulus(input string name, input logic signed [W-1:0] c_re,
                               input logic signed [W-1:0] c_im, input logic [TW-1:0] t,
                               output int lat);
    checkOutput({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_c_real = c_re;
    bus.in_c_imag = c_im;
    bus.in_tag    = t;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_c_real = '0;
    bus.in_c_imag = '0;
    bus.in_tag    = '0;
    lat = 0;
    while (!bus.out_valid && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) checkOutput({name, ".timeout"}, 64'd0, 64'd1);
  endtask

  // Check the result, stall for hold cycles, then release and check the bubble.
  task automatic collectResult(input string name, input int lat, input int exp_lat,
                               input int exp_iter, input bit exp_esc, input bit exp_per,
                               input logic [TW-1:0] exp_tag, input int hold);
    checkOutput({name, ".latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, ".iter"}, 64'(bus.out_iter), 64'(exp_iter));
    checkOutput({name, ".escaped"}, 64'(bus.out_escaped), 64'(exp_esc));
    checkOutput({name, ".periodic"}, 64'(bus.out_periodic), 64'(exp_per));
    checkOutput({name, ".tag"}, 64'(bus.out_tag), 64'(exp_tag));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      checkOutput({name, ".hold_iter"}, 64'(bus.out_iter), 64'(exp_iter));
      checkOutput({name, ".hold_tag"}, 64'(bus.out_tag), 64'(exp_tag));
      checkOutput({name, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({name, ".released_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, ".released_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int  lat;
    bit  stale;

    bus.in_valid  = 1'b0;
    bus.in_c_real = '0;
    bus.in_c_imag = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset.out_iter", 64'(bus.out_iter), 64'd0);
    checkOutput("reset.out_escaped", 64'(bus.out_escaped), 64'd0);
    checkOutput("reset.out_periodic", 64'(bus.out_periodic), 64'd0);
    checkOutput("reset.out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] c = 0");
    applyStimulus("c0", fx(0), fx(0), 16'hA001, lat);
    collectResult("c0", lat, PCHK ? 3 : MAXI + 1, MAXI, 1'b0, PCHK, 16'hA001, 0);

    $display("[TB] c = 2 (boundary |z|^2 = 4)");
    applyStimulus("c2", fx(2), fx(0), 16'hA002, lat);
    collectResult("c2", lat, 3, 2, 1'b1, 1'b0, 16'hA002, 0);

    $display("[TB] c = 1+1i");
    applyStimulus("c1p1i", fx(1), fx(1), 16'hA003, lat);
    collectResult("c1p1i", lat, 3, 2, 1'b1, 1'b0, 16'hA003, 0);

    $display("[TB] c = 3");
    applyStimulus("c3", fx(3), fx(0), 16'hA004, lat);
    collectResult("c3", lat, 2, 1, 1'b1, 1'b0, 16'hA004, 0);

    $display("[TB] c = 2i");
    applyStimulus("c2i", fx(0), fx(2), 16'hA005, lat);
    collectResult("c2i", lat, 3, 2, 1'b1, 1'b0, 16'hA005, 0);

    $display("[TB] c = -2");
    applyStimulus("cm2", fx(-2), fx(0), 16'hA006, lat);
    collectResult("cm2", lat, PCHK ? 4 : MAXI + 1, MAXI, 1'b0, PCHK, 16'hA006, 0);

    $display("[TB] c = -1");
    applyStimulus("cm1", fx(-1), fx(0), 16'hA007, lat);
    collectResult("cm1", lat, PCHK ? 5 : MAXI + 1, MAXI, 1'b0, PCHK, 16'hA007, 0);

    $display("[TB] back-to-back jobs with stalled consumer");
    applyStimulus("b2b1", fx(2), fx(0), 16'h0001, lat);
    collectResult("b2b1", lat, 3, 2, 1'b1, 1'b0, 16'h0001, 5);
    applyStimulus("b2b2", fx(1), fx(1), 16'h0002, lat);
    collectResult("b2b2", lat, 3, 2, 1'b1, 1'b0, 16'h0002, 5);

    $display("[TB] reset during iteration");
    bus.in_valid  = 1'b1;
    bus.in_c_real = fx(0);
    bus.in_c_imag = fx(0);
    bus.in_tag    = 16'h00BB;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midjob.in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst.out_iter", 64'(bus.out_iter), 64'd0);
    checkOutput("rst.out_escaped", 64'(bus.out_escaped), 64'd0);
    checkOutput("rst.out_periodic", 64'(bus.out_periodic), 64'd0);
    checkOutput("rst.out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("rst.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst.in_ready", 64'(bus.in_ready), 64'd1);
    stale = 1'b0;
    for (int i = 0; i < MAXI + 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    checkOutput("post_rst.no_stale", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_engine.md
# mandelbrot_iter_engine

Sequential, parametrised Mandelbrot escape-time engine: accepts one complex point c over a valid/ready handshake and iterates z ← z² + c from z = 0, one iteration per clock. It returns the iteration count, an escaped flag and a pass-through tag over a second valid/ready handshake. It sits between the pixel-coordinate generator and the colour/framebuffer writer, and generalises the single-step combinational iteration logic to configurable Q-format width, iteration limit and job tagging.

## Interface
- WIDTH, 46: total bits of signed fixed-point c and z values.
- FRAC, 40: fractional bits; must satisfy FRAC ≤ WIDTH-3.
- ITER_W, 16: width of the iteration counter and out_iter.
- MAX_ITER, 1000: iteration limit; must satisfy 1 ≤ MAX_ITER < 2^ITER_W.
- TAG_W, 16: width of the opaque job tag.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a job is offered.
- in_ready  out  1  the engine can accept a job.
- in_c_real, in_c_imag  in  WIDTH  signed real and imaginary parts of c.
- in_tag  in  TAG_W  job tag.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer takes the result.
- out_iter  out  ITER_W  iteration count.
- out_escaped  out  1  1 when the point escaped.
- out_periodic  out  1  1 when the job ended on a periodicity hit (macro only).
- out_tag  out  TAG_W  tag of the job.

## Operation
- FSM states: IDLE, ITER, DONE. Reset state is IDLE.
- Reset values: every register clears to 0, so out_valid=0, out_iter=0, out_escaped=0, out_periodic=0, out_tag=0, and in_ready=1 in IDLE.
- in_ready = (state==IDLE).
- Accept (in_valid & in_ready):
  - latch c and tag;
  - set z=0 and iter=0;
  - move to ITER.
- Each ITER cycle, using the current z:
  - Compute the full 2·WIDTH-bit signed products zr², zi² and zr·zi, then arithmetic-shift each right by FRAC.
  - mag = zr²+zi², evaluated at 2·WIDTH-FRAC+1 bits so that it never wraps.
  - If mag > (4 << FRAC), with a strict compare: go to DONE with out_iter=iter and escaped=1.
  - Otherwise, if iter==MAX_ITER: go to DONE with out_iter=MAX_ITER and escaped=0.
  - Otherwise: zr ← zr²-zi²+cr and zi ← 2·zr·zi+ci, both truncated to WIDTH bits (wrap, no saturation); iter ← iter+1.
- DONE: out_* stay stable while out_valid=1. On out_ready, move to IDLE.
- out_valid is deasserted the cycle after out_ready and never drops before it.
- An asynchronous reset mid-job discards that job. No partial result is emitted.

## Timing
- One iteration per cycle.
- A job accepted at edge A that terminates with out_iter=n raises out_valid after edge A+n+1, giving a latency of n+1 cycles.
- The non-escaping worst case is MAX_ITER+1 cycles.
- The handshake costs one bubble: the cycle after the out_ready edge is IDLE, so the earliest next accept is one cycle after release.
- Throughput is 1 job per (n+3) cycles.
- in_c_* and in_tag are sampled only on the accept edge. out_ready outside DONE is ignored.

## Configuration
- MANDEL_PERIOD_CHECK_EN, when defined:
  - A snapshot register snap with a snap_vld bit is cleared on accept.
  - In an ITER cycle that neither escapes nor hits the limit, and has snap_vld=1 and z==snap, the job goes to DONE with out_iter=MAX_ITER, escaped=0, periodic=1.
  - Otherwise, when iter ≠ 0 and iter is a power of two, snap ← z and snap_vld ← 1. The compare uses the old snap.
  - Escape takes priority over the limit, and the limit takes priority over the periodicity hit.
- Without the macro: out_periodic is tied to 0 and there is no snapshot logic.

## Structure
- Shared package mandelbrot_pkg:
  - FSM state enum;
  - MANDEL_BOUND_INT = 4;
  - default WIDTH/FRAC/ITER_W constants, shared with the coordinate generator.
- One combinational sub-module, mandelbrot_step: it takes z and c and returns next_z and the escape flag. It is parametrised by WIDTH and FRAC and holds the multipliers and the bound compare.
- The engine holds the FSM, counter, registers and the optional snapshot.

## Test plan
- c=0+0i, MAX_ITER=1000, no macro -> out_iter=1000, escaped=0, out_valid 1001 cycles after accept.
- c=2.0+0i -> z sequence 0, 2, 6. |z|²=4 is not an escape. Expect out_iter=2, escaped=1, latency 3.
- c=1.0+1.0i -> z2=1+3i, mag 10 -> out_iter=2, escaped=1.
- Macro on:
  - c=-2.0 -> z 0, -2, 2, 2 -> periodic hit at iter 3: out_iter=MAX_ITER, periodic=1, latency 4.
  - c=0 -> hit at iter 2, latency 3.
- Back-to-back jobs with tags 0x0001 and 0x0002, with out_ready held low for 5 cycles -> outputs stay stable, in_ready=0 throughout, tags returned in order, one bubble between jobs.
- Assert rst_n low mid-ITER -> all outputs 0 immediately. After release, in_ready=1 and no stale result appears.
